// File: rtl/control_unit.sv
// Multicycle sequencer for the accumulator CPU: fetch, decode, memory access,
// branch evaluation, accumulator write-back and status update, with a memory timeout.
module control_unit #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic       clock,
   input  logic       status_reset,
   input  logic       start,
   input  logic [3:0] opcode,
   input  logic       flag_Z,
   input  logic       flag_N,
   input  logic       mem_ready,
   output logic       pc_wr,
   output logic       pc_src,
   output logic       ir_wr,
   output logic       mdr_wr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       addr_sel,
   output logic       acc_wr,
   output logic [1:0] acc_src,
   output logic       alu_op,
   output logic       alu_b_src,
   output logic       status_wr,
   output logic       halted,
   output logic       bus_error
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, MEM, EXEC, WB, STAT, HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_HLT  = 4'h0, OP_STO  = 4'h1, OP_LD   = 4'h2, OP_LDI  = 4'h3,
      OP_ADD  = 4'h4, OP_ADDI = 4'h5, OP_SUB  = 4'h6, OP_SUBI = 4'h7,
      OP_BEQ  = 4'h8, OP_BNE  = 4'h9, OP_BGT  = 4'hA, OP_BGE  = 4'hB,
      OP_BLT  = 4'hC, OP_BLE  = 4'hD, OP_JMP  = 4'hE, OP_NOP  = 4'hF
   } op_t;

   localparam logic [8:0] LIMIT    = 9'(WAIT_LIMIT);
   localparam bit         LIMIT_ON = (WAIT_LIMIT != 0);

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic [8:0] wait_cnt_inc;
   logic       mem_wait;
   logic       timeout;
   logic       taken;

   // A memory state is "waiting" on any cycle the bus has not answered yet.
   assign mem_wait     = ((state == FETCH) || (state == MEM)) && !mem_ready;
   assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;
   assign timeout      = mem_wait && LIMIT_ON && (wait_cnt_inc == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clock or posedge status_reset) begin
      if (status_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or posedge status_reset) begin
      if (status_reset) begin
         wait_cnt <= 8'd0;
      end else if (state_next != state) begin
         wait_cnt <= 8'd0;
      end else if (mem_wait && (wait_cnt != 8'hFF)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Sticky: only reset clears the timeout cause.
   always_ff @(posedge clock or posedge status_reset) begin
      if (status_reset) begin
         bus_error <= 1'b0;
      end else if (timeout) begin
         bus_error <= 1'b1;
      end
   end

   // NOTE: every variable written in a combinational block gets a default
   // first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  taken = flag_Z;
         OP_BNE:  taken = !flag_Z;
         OP_BGT:  taken = !flag_Z && !flag_N;
         OP_BGE:  taken = !flag_N;
         OP_BLT:  taken = flag_N;
         OP_BLE:  taken = flag_N || flag_Z;
         OP_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            if (mem_ready)    state_next = DECODE;
            else if (timeout) state_next = HALT;
         end
         DECODE: begin
            case (opcode)
               OP_HLT:                          state_next = HALT;
               OP_NOP:                          state_next = FETCH;
               OP_STO, OP_LD, OP_ADD, OP_SUB:   state_next = MEM;
               OP_LDI, OP_ADDI, OP_SUBI:        state_next = WB;
               default:                         state_next = EXEC;
            endcase
         end
         MEM: begin
            if (mem_ready)    state_next = (opcode == OP_STO) ? FETCH : WB;
            else if (timeout) state_next = HALT;
         end
         EXEC:    state_next = FETCH;
         WB:      state_next = STAT;
         STAT:    state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pc_wr     = 1'b0;
      pc_src    = 1'b0;
      ir_wr     = 1'b0;
      mdr_wr    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      addr_sel  = 1'b0;
      acc_wr    = 1'b0;
      acc_src   = 2'b00;
      alu_op    = 1'b0;
      alu_b_src = 1'b0;
      status_wr = 1'b0;
      halted    = 1'b0;
      case (state)
         FETCH: begin
            mem_rd = 1'b1;
            ir_wr  = mem_ready;
         end
         DECODE: begin
            pc_wr = 1'b1;
         end
         MEM: begin
            addr_sel = 1'b1;
            if (opcode == OP_STO) begin
               mem_wr = 1'b1;
            end else begin
               mem_rd = 1'b1;
               mdr_wr = mem_ready;
            end
         end
         EXEC: begin
            pc_wr  = taken;
            pc_src = taken;
         end
         WB: begin
            acc_wr = 1'b1;
            case (opcode)
               OP_LD:   acc_src = 2'b01;
               OP_LDI:  acc_src = 2'b10;
               OP_SUB:  alu_op  = 1'b1;
               OP_ADDI: alu_b_src = 1'b1;
               OP_SUBI: begin
                  alu_op    = 1'b1;
                  alu_b_src = 1'b1;
               end
               default: acc_src = 2'b00;
            endcase
         end
         STAT: begin
            status_wr = 1'b1;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: cycle-by-cycle vector table for the main
// instruction mix plus hand sequences for branches, timeout and async reset.
module tb_control_unit;

   // Output bundle layout:
   // [14] pc_wr [13] pc_src [12] ir_wr [11] mdr_wr [10] mem_rd [9] mem_wr
   // [8] addr_sel [7] acc_wr [6:5] acc_src [4] alu_op [3] alu_b_src
   // [2] status_wr [1] halted [0] bus_error
   typedef logic [14:0] out_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic       mem_ready;
      logic       start;
      out_t       exp;
   } vec_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic       z;
      logic       n;
      logic       taken;
   } br_t;

   logic       clock = 1'b0;
   logic       status_reset;
   logic       start;
   logic [3:0] opcode;
   logic       flag_Z;
   logic       flag_N;
   logic       mem_ready;

   logic       pc_wr, pc_src, ir_wr, mdr_wr, mem_rd, mem_wr, addr_sel, acc_wr;
   logic [1:0] acc_src;
   logic       alu_op, alu_b_src, status_wr, halted, bus_error;

   logic       pc_wr2, pc_src2, ir_wr2, mdr_wr2, mem_rd2, mem_wr2, addr_sel2, acc_wr2;
   logic [1:0] acc_src2;
   logic       alu_op2, alu_b_src2, status_wr2, halted2, bus_error2;

   out_t obs;
   out_t obs2;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   br_t  brs[$];

   always #5 clock = ~clock;

   control_unit #(.WAIT_LIMIT(15)) dut (
      .clock(clock), .status_reset(status_reset), .start(start), .opcode(opcode),
      .flag_Z(flag_Z), .flag_N(flag_N), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .mdr_wr(mdr_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .acc_wr(acc_wr),
      .acc_src(acc_src), .alu_op(alu_op), .alu_b_src(alu_b_src),
      .status_wr(status_wr), .halted(halted), .bus_error(bus_error)
   );

   control_unit #(.WAIT_LIMIT(4)) dut_t4 (
      .clock(clock), .status_reset(status_reset), .start(start), .opcode(opcode),
      .flag_Z(flag_Z), .flag_N(flag_N), .mem_ready(mem_ready),
      .pc_wr(pc_wr2), .pc_src(pc_src2), .ir_wr(ir_wr2), .mdr_wr(mdr_wr2),
      .mem_rd(mem_rd2), .mem_wr(mem_wr2), .addr_sel(addr_sel2), .acc_wr(acc_wr2),
      .acc_src(acc_src2), .alu_op(alu_op2), .alu_b_src(alu_b_src2),
      .status_wr(status_wr2), .halted(halted2), .bus_error(bus_error2)
   );

   assign obs  = {pc_wr, pc_src, ir_wr, mdr_wr, mem_rd, mem_wr, addr_sel, acc_wr,
                  acc_src, alu_op, alu_b_src, status_wr, halted, bus_error};
   assign obs2 = {pc_wr2, pc_src2, ir_wr2, mdr_wr2, mem_rd2, mem_wr2, addr_sel2, acc_wr2,
                  acc_src2, alu_op2, alu_b_src2, status_wr2, halted2, bus_error2};

   task automatic check(input string name, input out_t actual, input out_t expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      status_reset = 1'b1;
      start        = 1'b0;
      #2;
      status_reset = 1'b0;
      step();
   endtask

   task automatic add_vec(input logic [3:0] op, input logic rdy, input logic st, input out_t exp);
      vecs.push_back('{opcode: op, mem_ready: rdy, start: st, exp: exp});
   endtask

   task automatic add_br(input logic [3:0] op, input logic [2:0] mask);
      // mask bit 0: Z=0,N=0   bit 1: Z=0,N=1   bit 2: Z=1,N=0
      brs.push_back('{opcode: op, z: 1'b0, n: 1'b0, taken: mask[0]});
      brs.push_back('{opcode: op, z: 1'b0, n: 1'b1, taken: mask[1]});
      brs.push_back('{opcode: op, z: 1'b1, n: 1'b0, taken: mask[2]});
   endtask

   initial begin
      // Instruction mix, one row per cycle starting in IDLE.
      add_vec(4'h3, 1'b1, 1'b1, 15'h0000);  // IDLE, start
      add_vec(4'h3, 1'b1, 1'b0, 15'h1400);  // LDI: FETCH
      add_vec(4'h3, 1'b1, 1'b0, 15'h4000);  // DECODE
      add_vec(4'h3, 1'b1, 1'b0, 15'h00C0);  // WB acc_src=10
      add_vec(4'h3, 1'b1, 1'b0, 15'h0004);  // STAT
      add_vec(4'h4, 1'b1, 1'b0, 15'h1400);  // ADD: FETCH
      add_vec(4'h4, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h4, 1'b0, 1'b0, 15'h0500);  // MEM wait x3
      add_vec(4'h4, 1'b0, 1'b0, 15'h0500);
      add_vec(4'h4, 1'b0, 1'b0, 15'h0500);
      add_vec(4'h4, 1'b1, 1'b0, 15'h0D00);  // MEM ready, mdr_wr
      add_vec(4'h4, 1'b1, 1'b0, 15'h0080);  // WB add, MDR operand
      add_vec(4'h4, 1'b1, 1'b0, 15'h0004);
      add_vec(4'h1, 1'b1, 1'b0, 15'h1400);  // STO
      add_vec(4'h1, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h1, 1'b0, 1'b0, 15'h0300);  // MEM write, waiting
      add_vec(4'h1, 1'b1, 1'b0, 15'h0300);  // MEM write, done -> FETCH
      add_vec(4'h2, 1'b1, 1'b0, 15'h1400);  // LD
      add_vec(4'h2, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h2, 1'b1, 1'b0, 15'h0D00);
      add_vec(4'h2, 1'b1, 1'b0, 15'h00A0);
      add_vec(4'h2, 1'b1, 1'b0, 15'h0004);
      add_vec(4'h6, 1'b1, 1'b0, 15'h1400);  // SUB
      add_vec(4'h6, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h6, 1'b1, 1'b0, 15'h0D00);
      add_vec(4'h6, 1'b1, 1'b0, 15'h0090);
      add_vec(4'h6, 1'b1, 1'b0, 15'h0004);
      add_vec(4'h5, 1'b1, 1'b0, 15'h1400);  // ADDI
      add_vec(4'h5, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h5, 1'b1, 1'b0, 15'h0088);
      add_vec(4'h5, 1'b1, 1'b0, 15'h0004);
      add_vec(4'h7, 1'b1, 1'b0, 15'h1400);  // SUBI
      add_vec(4'h7, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h7, 1'b1, 1'b0, 15'h0098);
      add_vec(4'h7, 1'b1, 1'b0, 15'h0004);
      add_vec(4'hF, 1'b0, 1'b0, 15'h0400);  // NOP: FETCH wait
      add_vec(4'hF, 1'b1, 1'b0, 15'h1400);
      add_vec(4'hF, 1'b1, 1'b0, 15'h4000);
      add_vec(4'hE, 1'b1, 1'b0, 15'h1400);  // JMP
      add_vec(4'hE, 1'b1, 1'b0, 15'h4000);
      add_vec(4'hE, 1'b1, 1'b0, 15'h6000);  // EXEC taken
      add_vec(4'h0, 1'b1, 1'b0, 15'h1400);  // HLT
      add_vec(4'h0, 1'b1, 1'b0, 15'h4000);
      add_vec(4'h0, 1'b1, 1'b1, 15'h0002);  // HALT, start ignored
      add_vec(4'h0, 1'b1, 1'b0, 15'h0002);

      add_br(4'h8, 3'b100);  // BEQ
      add_br(4'h9, 3'b011);  // BNE
      add_br(4'hA, 3'b001);  // BGT
      add_br(4'hB, 3'b101);  // BGE
      add_br(4'hC, 3'b010);  // BLT
      add_br(4'hD, 3'b110);  // BLE

      status_reset = 1'b1;
      start        = 1'b1;
      opcode       = 4'h3;
      flag_Z       = 1'b0;
      flag_N       = 1'b0;
      mem_ready    = 1'b1;
      #1;
      check("reset_outputs", obs, 15'h0000);
      check("reset_outputs_t4", obs2, 15'h0000);
      step();
      check("reset_held_over_edge", obs, 15'h0000);

      do_reset();
      foreach (vecs[i]) begin
         opcode    = vecs[i].opcode;
         mem_ready = vecs[i].mem_ready;
         start     = vecs[i].start;
         #1;
         check($sformatf("seq[%0d]", i), obs, vecs[i].exp);
         step();
      end

      // Branch sweep: the EXEC cycle is the third after leaving IDLE.
      foreach (brs[i]) begin
         do_reset();
         opcode    = brs[i].opcode;
         flag_Z    = brs[i].z;
         flag_N    = brs[i].n;
         mem_ready = 1'b1;
         start     = 1'b1;
         step();
         start = 1'b0;
         step();
         step();
         check($sformatf("branch op=%h z=%b n=%b", brs[i].opcode, brs[i].z, brs[i].n),
               obs, brs[i].taken ? 15'h6000 : 15'h0000);
      end
      flag_Z = 1'b0;
      flag_N = 1'b0;

      // Timeout in FETCH with a 4-cycle limit.
      do_reset();
      opcode    = 4'h3;
      mem_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("timeout_wait[%0d]", k), obs2, 15'h0400);
         step();
      end
      check("timeout_halt", obs2, 15'h0003);
      check("no_timeout_limit15", obs, 15'h0400);
      start = 1'b1;
      step();
      start = 1'b0;
      check("timeout_start_ignored", obs2, 15'h0003);
      step();
      check("timeout_sticky", obs2, 15'h0003);

      // Ready arriving on the limit cycle completes the fetch.
      do_reset();
      opcode    = 4'hF;
      mem_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) step();
      mem_ready = 1'b1;
      #1;
      check("limit_ready_wins", obs2, 15'h1400);
      step();
      check("limit_ready_decode", obs2, 15'h4000);

      // Async reset in the middle of WB.
      do_reset();
      opcode    = 4'h3;
      mem_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("wb_before_reset", obs, 15'h00C0);
      #1;
      status_reset = 1'b1;
      #1;
      check("reset_mid_wb_immediate", obs, 15'h0000);
      step();
      status_reset = 1'b0;
      check("reset_mid_wb_idle", obs, 15'h0000);
      step();
      check("reset_mid_wb_no_stat", obs, 15'h0000);
      opcode = 4'h0;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("post_reset_fetch", obs, 15'h1400);
      step();
      check("post_reset_decode", obs, 15'h4000);
      step();
      check("post_reset_halted", obs, 15'h0002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the accumulator CPU datapath. It fetches and decodes each instruction and drives PC, IR, MDR, accumulator and memory strobes. It pulses the status register write one cycle after every accumulator write, so flag_Z/flag_N always reflect the latest accumulator value. It evaluates conditional branches from those flags and stops the core on HLT or on a memory timeout.

## Interface
- WAIT_LIMIT, 15: maximum cycles to wait for mem_ready in a memory state before the bus error fires. Range 0..255; 0 disables the timeout.
- clock  in  1  system clock, rising edge.
- status_reset  in  1  asynchronous, active-high reset. Reset is status_reset, asynchronous, active-high; clock is clock.
- start  in  1  leaves IDLE when high.
- opcode  in  4  IR opcode field, stable from DECODE onward.
- flag_Z, flag_N  in  1  from the status register.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_wr, pc_src  out  1  PC load; pc_src 0 = PC+1, 1 = IR operand (branch target).
- ir_wr, mdr_wr  out  1  IR / memory data register load.
- mem_rd, mem_wr, addr_sel  out  1  memory strobes; addr_sel 0 = PC, 1 = IR operand.
- acc_wr  out  1  accumulator load.
- acc_src  out  2  00 = ALU, 01 = MDR, 10 = immediate.
- alu_op  out  1  0 = add, 1 = sub.
- alu_b_src  out  1  0 = MDR, 1 = immediate.
- status_wr  out  1  status register write.
- halted, bus_error  out  1  sticky halt indication / timeout cause.

## Operation
- Opcodes:
  - 0 HLT, 1 STO, 2 LD, 3 LDI, 4 ADD, 5 ADDI, 6 SUB, 7 SUBI.
  - 8 BEQ, 9 BNE, A BGT, B BGE, C BLT, D BLE, E JMP, F NOP.
- Branch taken conditions:
  - BEQ: Z.
  - BNE: !Z.
  - BGT: !Z & !N.
  - BGE: !N.
  - BLT: N.
  - BLE: N | Z.
  - JMP: always.
- States: IDLE, FETCH, DECODE, MEM, EXEC, WB, STAT, HALT.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: mem_rd=1, addr_sel=0. On mem_ready: ir_wr=1 -> DECODE. Otherwise stay.
- DECODE: pc_wr=1, pc_src=0. Next state by opcode:
  - HLT -> HALT.
  - NOP -> FETCH.
  - 8..E -> EXEC.
  - LDI/ADDI/SUBI -> WB.
  - STO/LD/ADD/SUB -> MEM.
- MEM: addr_sel=1. mem_wr=1 for STO; mem_rd=1 otherwise. On mem_ready: STO -> FETCH; others assert mdr_wr=1 -> WB.
- EXEC: if taken, pc_wr=1 and pc_src=1. Not taken: no writes. Always -> FETCH.
- WB: acc_wr=1, then -> STAT.
  - LD: acc_src=01.
  - LDI: acc_src=10.
  - ADD/SUB: acc_src=00, alu_b_src=0, alu_op=0/1.
  - ADDI/SUBI: acc_src=00, alu_b_src=1, alu_op=0/1.
- STAT: status_wr=1 -> FETCH. STO, branches, NOP and HLT never write status.
- HALT: halted=1, all strobes 0. Absorbing; start is ignored. Only reset exits.
- Wait counter (8-bit):
  - Cleared on entering FETCH or MEM.
  - Increments each cycle mem_ready=0 in those states.
  - If WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT with mem_ready still 0: no strobe commits, next state HALT, bus_error=1 (sticky).
  - mem_ready=1 on the same cycle as the limit wins: the access completes normally.

## Timing
- All outputs are Moore-decoded from state, except these same-cycle terms:
  - ir_wr and mdr_wr are qualified by mem_ready.
  - pc_wr in EXEC is qualified by the flags.
- Reset: async to IDLE. All outputs 0, including halted and bus_error. Counter 0. Takes effect immediately mid-instruction; no partial write completes after the reset edge.
- Latency with zero-wait memory:
  - NOP 2 cycles; branch/JMP 3; STO 3; LDI/ADDI/SUBI 4; LD/ADD/SUB 5; HLT 2, then halted.
- Each mem_ready=0 cycle in FETCH/MEM adds one cycle.
- Flags read in EXEC are the values written by the previous instruction's STAT; the STAT-to-EXEC distance is at least 3 cycles.

## Test plan
- Reset, then start=1 with mem_ready=1 and opcode LDI:
  - States FETCH, DECODE, WB, STAT.
  - acc_wr and acc_src=10 in cycle 3.
  - status_wr in cycle 4, then FETCH again.
- ADD with mem_ready low for 3 cycles in MEM (WAIT_LIMIT=15):
  - MEM held 4 cycles.
  - mdr_wr on the ready cycle.
  - WB: acc_wr=1, acc_src=00, alu_op=0, alu_b_src=0; STAT next.
- Branch sweep, opcodes 8..D, with (Z,N) = 00, 01, 10:
  - pc_wr/pc_src=1 in EXEC exactly per the condition table. Example: BGT taken only for Z=0,N=0.
- STO: mem_wr=1 and addr_sel=1 in MEM. No acc_wr or status_wr anywhere in the instruction.
- Timeout with WAIT_LIMIT=4 and mem_ready held 0 in FETCH:
  - HALT entered after 4 waiting cycles; halted=1, bus_error=1, ir_wr never high.
  - A start pulse afterwards causes no change.
- Async reset asserted mid-WB:
  - acc_wr drops immediately, state IDLE, no status_wr follows.
  - HLT then gives halted=1 two cycles after FETCH completes, bus_error=0.
